fft12_frame_loader: RTL
=======================

Name: fft12_frame_loader

Overview:
- Upstream input stage for the 12-point FFT core (cbaFFT12).
- Accepts a serial stream of complex 16-bit samples with a valid/ready handshake.
- Assembles the samples into 12-sample frames in a ping-pong buffer.
- Presents each complete frame to the FFT core as 12 parallel real/imag words, held stable under a valid/ready handshake.

Parameters:
- W, 16, sample width for real and imaginary parts; matches the FFT core inputs.
- N, 12, samples per frame; fixed at 12 for cbaFFT12, parameterised only for the index counter width.
- SCALE_SHIFT, 8, left-shift applied when the optional scaling feature is compiled in; 8 gives Q8 (integer × 256, as in the FFT test vectors).

Ports:
- clk  in  1  single clock domain; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  loader can accept a sample this cycle.
- in_sof  in  1  start-of-frame marker, qualified by in_valid.
- in_re  in  W  sample real part, two's complement.
- in_im  in  W  sample imaginary part, two's complement.
- out_valid  out  1  a complete frame is presented.
- out_ready  in  1  FFT side consumes the frame.
- out_re  out  N*W  frame real parts; sample k at bits [W*k+W-1 : W*k]; k=0 drives x1r … k=11 drives x12r.
- out_im  out  N*W  frame imaginary parts, same packing; drives x1i … x12i.
- sof_err  out  1  one-cycle pulse: a partial frame was discarded on in_sof.
- frame_cnt  out  16  count of frames delivered; wraps at 65535 → 0.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - Reset mid-operation discards both banks and any partial frame.
- Reset values:
  - in_ready=1, out_valid=0, sof_err=0, frame_cnt=0.
  - out_re=0, out_im=0, wr_idx=0, wr_bank=0, rd_bank=0, full[1:0]=00.
- Storage: two banks (0/1), each holding N complex words; full[b] marks a complete bank.
- Accept:
  - in_ready = !full[wr_bank]; combinational from registers only.
  - A sample is accepted when in_valid && in_ready.
  - The accepted sample is written to bank wr_bank at index wr_idx.
  - wr_idx then increments.
- Frame completion:
  - Acceptance at wr_idx==N-1 sets full[wr_bank], toggles wr_bank and sets wr_idx=0.
- in_sof handling:
  - Accepted with wr_idx==0: normal start of frame.
  - Accepted with wr_idx!=0: the partial frame is dropped, sof_err pulses next cycle, and the sample is written at index 0 (wr_idx becomes 1).
  - in_sof is ignored when in_ready=0.
- Output:
  - out_valid = full[rd_bank]; out_re/out_im are driven from bank rd_bank.
  - Output is stable while out_valid && !out_ready.
  - On out_valid && out_ready: clear full[rd_bank], toggle rd_bank, increment frame_cnt.
- Latency:
  - The sample completing a frame is accepted in cycle T; out_valid=1 in cycle T+1, provided the read side is not still holding the other bank.
  - Throughput is 1 sample/cycle sustained when out_ready is held high.
- Back-pressure:
  - Both banks full → in_ready=0.
  - in_ready re-asserts the cycle after the first frame handshake.
- Simultaneous events:
  - Completing a frame and handshaking the other bank in the same cycle is legal; both full bits update independently.
  - An in_sof error coinciding with an output handshake is legal; both take effect.
- Arithmetic: no arithmetic on samples (pass-through) unless the optional feature is compiled in.

Optional Feature:
- FFT12_LOADER_SCALE_EN defined:
  - Each accepted in_re/in_im is arithmetically shifted left by SCALE_SHIFT before storage.
  - The result saturates to +(2^(W-1)-1) / -(2^(W-1)).
  - Example: in_re=10 → 2560; in_re=200 → 32767.
- Undefined: samples are stored unmodified, and SCALE_SHIFT is unused.

Decomposition:
- Package fft12_pkg holds:
  - constants FFT12_N=12 and FFT12_W=16;
  - a typedef for a complex sample struct {re, im};
  - the bit-slice helper for the packed out_re/out_im.
- Sub-module fft12_sample_bank:
  - one N-entry register bank with write port and full flag;
  - instantiated twice for ping-pong operation.
- Saturating shift is a function in fft12_pkg.

Test Plan:
- Frame A:
  - Stimulus: stream 512,1024,768,2560,768,1024,512,2048,256,2048,2304,256 (im=0), out_ready=1.
  - Response: out_valid rises 1 cycle after the 12th accept, x1r..x12r match in order, frame_cnt=1.
- Back-pressure:
  - Stimulus: out_ready=0, stream frames A, B and a third frame continuously.
  - Response: in_ready drops after 24 accepts; raising out_ready for 1 cycle yields A, and in_ready returns next cycle; B follows unchanged.
- Mid-frame restart:
  - Stimulus: 5 samples, then in_sof with frame C (1792,768,…,256).
  - Response: sof_err pulses once; the delivered frame equals C exactly.
- Reset mid-frame:
  - Stimulus: rst for 1 cycle after 7 samples with one frame pending.
  - Response: out_valid=0, in_ready=1, frame_cnt=0; the next 12 samples form frame D cleanly.
- Sustained streaming:
  - Stimulus: 100 back-to-back frames, out_ready=1.
  - Response: no in_ready gaps; frame_cnt=100.
- Scaling, FFT12_LOADER_SCALE_EN only:
  - Stimulus: input A as integers 2,4,3,10,… and inputs 200 and -200.
  - Response: output equals frame A; 200 → 32767, -200 → -32768.

Source files
------------

// File: rtl/fft12_pkg.sv
// Shared constants, sample type and helpers for the fft12 frame loader slice.
// sat_shl is only used when FFT12_LOADER_SCALE_EN is defined.
package fft12_pkg;

    localparam int FFT12_N = 12;
    localparam int FFT12_W = 16;

    typedef struct packed {
        logic signed [FFT12_W-1:0] re;
        logic signed [FFT12_W-1:0] im;
    } fft12_sample_t;

    // Low bit of lane k in the packed out_re/out_im buses.
    function automatic int lane_lo(input int k);
        return k * FFT12_W;
    endfunction

    // Arithmetic left shift clamped to the signed W-bit range.
    function automatic logic signed [FFT12_W-1:0] sat_shl(
        input logic signed [FFT12_W-1:0] x,
        input int unsigned               sh
    );
        logic signed [2*FFT12_W-1:0] wide;
        logic signed [2*FFT12_W-1:0] max_v;
        logic signed [2*FFT12_W-1:0] min_v;
        wide  = {{FFT12_W{x[FFT12_W-1]}}, x};
        wide  = wide <<< sh;
        max_v = {{(FFT12_W+1){1'b0}}, {(FFT12_W-1){1'b1}}};
        min_v = {{(FFT12_W+1){1'b1}}, {(FFT12_W-1){1'b0}}};
        if (wide > max_v) begin
            return max_v[FFT12_W-1:0];
        end
        if (wide < min_v) begin
            return min_v[FFT12_W-1:0];
        end
        return wide[FFT12_W-1:0];
    endfunction

endpackage

// File: rtl/fft12_frame_loader_if.sv
// Sample-in and frame-out handshakes of the fft12 frame loader.
// slave is the loader side, master the producer/FFT side.
interface fft12_frame_loader_if;
    import fft12_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    logic                         in_sof;
    logic [FFT12_W-1:0]           in_re;
    logic [FFT12_W-1:0]           in_im;
    logic                         out_valid;
    logic                         out_ready;
    logic [FFT12_N*FFT12_W-1:0]   out_re;
    logic [FFT12_N*FFT12_W-1:0]   out_im;

    modport slave (
        input  in_valid, in_sof, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im
    );

    modport master (
        output in_valid, in_sof, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im
    );

endinterface

// File: rtl/fft12_sample_bank.sv
// One N-entry complex sample bank with an indexed write port and a full flag.
// Two of these form the loader's ping-pong buffer.
module fft12_sample_bank
    import fft12_pkg::*;
#(
    parameter int N = FFT12_N,
    localparam int IDX_W = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  fft12_sample_t             wr_data,
    input  logic                      set_full,
    input  logic                      clr_full,
    output logic                      full,
    output fft12_sample_t [N-1:0]     rd_data
);

    fft12_sample_t [N-1:0] entry_q;
    fft12_sample_t [N-1:0] entry_d;
    logic                  full_q;
    logic                  full_d;

    always_comb begin
        entry_d = entry_q;
        for (int i = 0; i < N; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                entry_d[i] = wr_data;
            end
        end
    end

    // set and clear never coincide: set needs an empty bank, clear a full one.
    always_comb begin
        full_d = full_q;
        if (set_full) begin
            full_d = 1'b1;
        end
        if (clr_full) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
            full_q  <= 1'b0;
        end else begin
            entry_q <= entry_d;
            full_q  <= full_d;
        end
    end

    assign full    = full_q;
    assign rd_data = entry_q;

endmodule

// File: rtl/fft12_frame_loader.sv
// Serial-to-frame loader feeding cbaFFT12 through a two-bank ping-pong buffer.
// Optional build macro FFT12_LOADER_SCALE_EN: saturating <<SCALE_SHIFT on store.
module fft12_frame_loader
    import fft12_pkg::*;
#(
    parameter int          W           = FFT12_W,
    parameter int          N           = FFT12_N,
    parameter int unsigned SCALE_SHIFT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fft12_frame_loader_if.slave    io,
    output logic                   sof_err,
    output logic [15:0]            frame_cnt
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d, wr_addr;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  sof_err_q, sof_err_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  wr_en;
    logic                  accept;
    logic                  out_valid;
    logic [1:0]            full;
    logic [1:0]            set_full;
    logic [1:0]            clr_full;
    logic [1:0]            bank_wr_en;
    fft12_sample_t         wr_sample;
    fft12_sample_t [N-1:0] bank_data [2];

`ifdef FFT12_LOADER_SCALE_EN
    assign wr_sample = '{re: sat_shl(io.in_re, SCALE_SHIFT),
                         im: sat_shl(io.in_im, SCALE_SHIFT)};
`else
    logic [31:0] unused_scale_shift;
    assign unused_scale_shift = 32'(SCALE_SHIFT);
    assign wr_sample = '{re: io.in_re, im: io.in_im};
`endif

    assign io.in_ready = !full[wr_bank_q];
    assign accept      = io.in_valid && !full[wr_bank_q];
    assign out_valid   = full[rd_bank_q];
    assign io.out_valid = out_valid;
    assign bank_wr_en  = {wr_en & wr_bank_q, wr_en & ~wr_bank_q};

    always_comb begin
        wr_idx_d    = wr_idx_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        frame_cnt_d = frame_cnt_q;
        sof_err_d   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = wr_idx_q;
        set_full    = '0;
        clr_full    = '0;

        if (accept) begin
            wr_en = 1'b1;
            if (io.in_sof && (wr_idx_q != '0)) begin
                // Abandon the partial frame; this sample restarts it at slot 0.
                wr_addr   = '0;
                wr_idx_d  = IDX_W'(1);
                sof_err_d = 1'b1;
            end else if (wr_idx_q == IDX_W'(N-1)) begin
                set_full[wr_bank_q] = 1'b1;
                wr_bank_d           = !wr_bank_q;
                wr_idx_d            = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        if (out_valid && io.out_ready) begin
            clr_full[rd_bank_q] = 1'b1;
            rd_bank_d           = !rd_bank_q;
            frame_cnt_d         = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            sof_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            sof_err_q   <= sof_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        fft12_sample_bank #(.N(N)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (bank_wr_en[gi]),
            .wr_idx   (wr_addr),
            .wr_data  (wr_sample),
            .set_full (set_full[gi]),
            .clr_full (clr_full[gi]),
            .full     (full[gi]),
            .rd_data  (bank_data[gi])
        );
    end

    // Banks reset to zero, so the idle output bus reads zero after reset.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign io.out_re[lane_lo(gi) +: W] = rd_bank_q ? bank_data[1][gi].re : bank_data[0][gi].re;
        assign io.out_im[lane_lo(gi) +: W] = rd_bank_q ? bank_data[1][gi].im : bank_data[0][gi].im;
    end

    assign sof_err   = sof_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
